// File: rtl/change_pkg.sv
// Shared definitions for the parametrised change dispenser: FSM encoding and width helper.
package change_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDisp = 2'd2,
        StDone = 2'd3
    } state_e;

    // Ceiling log2, never below 1 so a single-denomination build still has a legal index port.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/change_coin_sel.sv
// Priority coin selector: picks the largest denomination that fits the remainder and is in stock.
module change_coin_sel
    import change_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NCOIN   = 4,
    parameter int unsigned STOCK_W = 6
) (
    input  logic [DATA_W-1:0]        rem_i,
    input  logic [NCOIN*DATA_W-1:0]  coin_vals_i,
    input  logic [NCOIN*STOCK_W-1:0] stock_i,
    output logic                     sel_valid_o,
    output logic [clog2(NCOIN)-1:0]  sel_idx_o
);

    localparam int unsigned IdxW = clog2(NCOIN);

    // Scan from the smallest coin up so the lowest qualifying index wins last.
    always_comb begin
        sel_valid_o = 1'b0;
        sel_idx_o   = '0;
        for (int i = NCOIN - 1; i >= 0; i--) begin
            if ((coin_vals_i[(NCOIN-1-i)*DATA_W +: DATA_W] <= rem_i) &&
                (stock_i[(NCOIN-1-i)*STOCK_W +: STOCK_W] != '0)) begin
                sel_valid_o = 1'b1;
                sel_idx_o   = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser_n.sv
// Change dispenser: pays an amount one coin per cycle, largest coin first, tracking coin stock.
module change_dispenser_n
    import change_pkg::*;
#(
    parameter int unsigned                    DATA_W     = 8,
    parameter int unsigned                    NCOIN      = 4,
    parameter logic [NCOIN*DATA_W-1:0]        COIN_VALS  = {8'd50, 8'd20, 8'd10, 8'd5},
    parameter int unsigned                    STOCK_W    = 6,
    parameter int unsigned                    INIT_STOCK = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_rdy,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      refill_en,
    input  logic [clog2(NCOIN)-1:0]   refill_idx,
    input  logic [STOCK_W-1:0]        refill_cnt,
    output logic                      out_rdy,
    output logic                      coin_valid,
    output logic [clog2(NCOIN)-1:0]   coin_idx,
    output logic                      state_cmp,
    output logic [DATA_W-1:0]         data_out,
    output logic                      err,
    output logic [NCOIN*STOCK_W-1:0]  stock_out
);

    localparam int unsigned IdxW = clog2(NCOIN);

    state_e                     state_q, state_d;
    logic [DATA_W-1:0]          rem_q, rem_d;
    logic [NCOIN*STOCK_W-1:0]   stock_q, stock_d;
    logic                       coin_valid_q, coin_valid_d;
    logic [IdxW-1:0]            coin_idx_q, coin_idx_d;
    logic                       state_cmp_q, state_cmp_d;
    logic [DATA_W-1:0]          data_out_q, data_out_d;
    logic                       err_q, err_d;

    logic                       sel_valid;
    logic [IdxW-1:0]            sel_idx;
    logic [DATA_W-1:0]          sel_val;

    change_coin_sel #(
        .DATA_W  (DATA_W),
        .NCOIN   (NCOIN),
        .STOCK_W (STOCK_W)
    ) u_coin_sel (
        .rem_i       (rem_q),
        .coin_vals_i (COIN_VALS),
        .stock_i     (stock_q),
        .sel_valid_o (sel_valid),
        .sel_idx_o   (sel_idx)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_rdy) state_d = StLoad;
            StLoad: state_d = StDisp;
            StDisp: if ((rem_q == '0) || !sel_valid) state_d = StDone;
            StDone: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        out_rdy = (state_q == StIdle);
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NCOIN; i++) begin
            if (IdxW'(i) == sel_idx) sel_val = COIN_VALS[(NCOIN-1-i)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        logic [STOCK_W:0] sum;
        sum          = '0;
        rem_d        = rem_q;
        stock_d      = stock_q;
        coin_valid_d = 1'b0;
        coin_idx_d   = coin_idx_q;
        state_cmp_d  = 1'b0;
        data_out_d   = data_out_q;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (refill_en) begin
                    for (int i = 0; i < NCOIN; i++) begin
                        if (IdxW'(i) == refill_idx) begin
                            sum = {1'b0, stock_q[(NCOIN-1-i)*STOCK_W +: STOCK_W]} +
                                  {1'b0, refill_cnt};
                            stock_d[(NCOIN-1-i)*STOCK_W +: STOCK_W] =
                                sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
                        end
                    end
                end
            end
            StLoad: rem_d = data_in;
            StDisp: begin
                if (rem_q == '0) begin
                    state_cmp_d = 1'b1;
                    data_out_d  = rem_q;
                    err_d       = 1'b0;
                end else if (sel_valid) begin
                    coin_valid_d = 1'b1;
                    coin_idx_d   = sel_idx;
                    rem_d        = rem_q - sel_val;
                    for (int i = 0; i < NCOIN; i++) begin
                        if (IdxW'(i) == sel_idx) begin
                            stock_d[(NCOIN-1-i)*STOCK_W +: STOCK_W] =
                                stock_q[(NCOIN-1-i)*STOCK_W +: STOCK_W] - 1'b1;
                        end
                    end
                end else begin
                    state_cmp_d = 1'b1;
                    data_out_d  = rem_q;
                    err_d       = 1'b1;
                end
            end
            StDone: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q        <= '0;
            stock_q      <= {NCOIN{STOCK_W'(INIT_STOCK)}};
            coin_valid_q <= 1'b0;
            coin_idx_q   <= '0;
            state_cmp_q  <= 1'b0;
            data_out_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            rem_q        <= rem_d;
            stock_q      <= stock_d;
            coin_valid_q <= coin_valid_d;
            coin_idx_q   <= coin_idx_d;
            state_cmp_q  <= state_cmp_d;
            data_out_q   <= data_out_d;
            err_q        <= err_d;
        end
    end

    assign coin_valid = coin_valid_q;
    assign coin_idx   = coin_idx_q;
    assign state_cmp  = state_cmp_q;
    assign data_out   = data_out_q;
    assign err        = err_q;
    assign stock_out  = stock_q;

endmodule

// File: doc/change_dispenser_n.md
Name: change_dispenser_n

Overview:
Parametrised successor to the ticket machine's change block. It takes a change amount and dispenses it one coin per cycle, largest coin first, over N configurable denominations. It tracks per-denomination coin stock and flags when exact change cannot be paid. It sits after the payment/price-compare stage and drives the coin-ejector interface.

Parameters:
DATA_W, 8, width of amount and coin values
NCOIN, 4, number of denominations (index 0 = largest)
COIN_VALS, {8'd50,8'd20,8'd10,8'd5}, packed NCOIN*DATA_W values, index 0 in MSBs; strictly descending, nonzero
STOCK_W, 6, width of each stock counter
INIT_STOCK, 8, stock value loaded into every counter at reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
in_rdy  in  1  one-cycle request pulse; amount follows on next cycle
data_in  in  DATA_W  change amount, sampled in LOAD
refill_en  in  1  stock refill strobe, honoured only in IDLE
refill_idx  in  clog2(NCOIN)  denomination to refill
refill_cnt  in  STOCK_W  coins added (saturating)
out_rdy  out  1  high in IDLE (ready for request)
coin_valid  out  1  one-cycle pulse per coin ejected
coin_idx  out  clog2(NCOIN)  denomination of ejected coin
state_cmp  out  1  one-cycle completion pulse
data_out  out  DATA_W  remaining unpaid amount, valid with state_cmp
err  out  1  valid with state_cmp: 1 = exact change impossible
stock_out  out  NCOIN*STOCK_W  current stock counts, packed like COIN_VALS

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; out_rdy=1; coin_valid, state_cmp, err=0; coin_idx=0; data_out=0; every stock counter = INIT_STOCK; remaining register = 0. Reset overrides everything, including mid-dispense; coins already pulsed are not restored.
- FSM states: IDLE, LOAD, DISP, DONE.
- IDLE: out_rdy=1. in_rdy=1 -> LOAD. refill_en=1 -> stock[refill_idx] += refill_cnt, saturating at 2^STOCK_W-1. in_rdy and refill_en in the same cycle: both take effect.
- LOAD: rem <= data_in; -> DISP. in_rdy is ignored outside IDLE.
- DISP, each cycle:
  - sel = lowest index i with COIN_VALS[i] <= rem and stock[i] > 0.
  - If rem==0: -> DONE with err=0.
  - Else if sel is found: coin_valid=1, coin_idx=sel, rem -= COIN_VALS[sel], stock[sel] -= 1.
  - Else: -> DONE with err=1. No coin is ejected.
  - An amount of 0 goes LOAD -> DISP -> DONE with no coins.
- DONE: state_cmp=1 for one cycle, data_out=rem, err as decided; -> IDLE.
- Latency: k coins -> state_cmp asserts k+2 cycles after LOAD.
- coin_valid, coin_idx, state_cmp, data_out and err are registered outputs. data_out and err hold their values until the next DONE; coin_idx holds its last value.
- Arithmetic is unsigned DATA_W. A subtraction cannot underflow, because selection guarantees value <= rem.
- refill_en outside IDLE is dropped.

Decomposition:
- Shared package change_pkg: FSM state encodings (IDLE=2'd0, LOAD=2'd1, DISP=2'd2, DONE=2'd3) and a clog2 function.
- One sub-module, change_coin_sel: combinational priority selector. Inputs rem, COIN_VALS, stock vector. Outputs sel_valid, sel_idx.
- Top level holds the FSM, rem, and the stock registers.

Test Plan:
- Reset then in_rdy, data_in=8'hFA (250) -> 5 coin_valid pulses, all coin_idx=0; state_cmp with data_out=0, err=0; stock[0]=3.
- Following 200 -> coins idx 0,0,0,1,1,2 (50,50,50,20,20,10); data_out=0, err=0; stock[0]=0.
- Amount 7 -> one coin idx 3 (5), then state_cmp with data_out=2, err=1.
- Amount 0 -> no coin_valid; state_cmp 2 cycles after LOAD with data_out=0, err=0.
- Refill in IDLE: idx 0, cnt 60 with stock 3 -> stock[0]=63 (saturated). Refill asserted during DISP -> stock unchanged.
- rst=0 asserted in DISP after 2 coins of a 250 request -> next cycle IDLE, out_rdy=1, no further coins, all stock=INIT_STOCK.
